fpga_multi_sensor_core: RTL and testbench



---
 rtl/fpga_multi_sensor_core.sv | 223 ++++++++++++++++++++++
 tb/tb_fpga_multi_sensor_core.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_multi_sensor_core.sv
//------------------------------------------------------------------------------
// Module   : fpga_multi_sensor_core
// Brief    : UART request parser driving N DHT11 readers, with checksum
//            validation, sensor/receive timeouts and 1- or 3-byte responses.
// Revision : 1.0 - initial multi-sensor release
//------------------------------------------------------------------------------
`default_nettype none

module fpga_multi_sensor_core #(
  parameter logic [7:0] ADDRESS     = 8'h00,
  parameter int         N_SENSORS   = 4,
  parameter int         DTH_TIMEOUT = 50_000_000,
  parameter int         RX_TIMEOUT  = 5_000_000
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic [7:0]             i_Rx_Data,
  input  logic                   i_Rx_Done,
  input  logic [40*N_SENSORS-1:0] i_Dth_Data,
  input  logic [N_SENSORS-1:0]   i_Dth_Done,
  input  logic [N_SENSORS-1:0]   i_Dth_Error,
  input  logic                   i_Tx_Done,
  output logic [7:0]             o_Tx_Data,
  output logic                   o_Tx_Start,
  output logic [N_SENSORS-1:0]   o_Dth_Start,
  output logic                   o_Busy
);

  localparam int c_MAX_TIMEOUT = (DTH_TIMEOUT > RX_TIMEOUT) ? DTH_TIMEOUT : RX_TIMEOUT;
  localparam int c_CNT_W       = $clog2(c_MAX_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_DTH_LAST = c_CNT_W'(DTH_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_RX_LAST  = c_CNT_W'(RX_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SKIP     = 3'd1,
    S_RX_CMD   = 3'd2,
    S_RX_CHAN  = 3'd3,
    S_CHECK    = 3'd4,
    S_DTH_WAIT = 3'd5,
    S_TX_SEND  = 3'd6,
    S_TX_WAIT  = 3'd7
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_count;
  logic [1:0]           r_skip;
  logic [7:0]           r_cmd;
  logic [7:0]           r_chan;
  logic [7:0]           r_resp [3];
  logic [1:0]           r_len;
  logic [1:0]           r_idx;

  logic [39:0]          w_slice;
  logic                 w_done;
  logic                 w_error;
  logic [N_SENSORS-1:0] w_onehot;
  logic [7:0]           w_sum;
  logic                 w_cmd_ok;
  logic                 w_chan_ok;
  logic                 w_rx_expired;

  // Route the selected channel's reading and flags; all others are ignored.
  always_comb begin
    w_slice  = '0;
    w_done   = 1'b0;
    w_error  = 1'b0;
    w_onehot = '0;
    for (int k = 0; k < N_SENSORS; k++) begin
      if (r_chan == 8'(k)) begin
        w_slice     = i_Dth_Data[40*k +: 40];
        w_done      = i_Dth_Done[k];
        w_error     = i_Dth_Error[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  assign w_sum        = w_slice[7:0] + w_slice[15:8] + w_slice[23:16] + w_slice[31:24];
  assign w_cmd_ok     = (r_cmd == 8'h03) || (r_cmd == 8'h04) || (r_cmd == 8'h05);
  assign w_chan_ok    = (r_chan < 8'(N_SENSORS));
  assign w_rx_expired = (r_count == c_RX_LAST);
  assign o_Busy       = (r_state != S_IDLE);

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_skip      <= '0;
      r_cmd       <= '0;
      r_chan      <= '0;
      r_resp[0]   <= '0;
      r_resp[1]   <= '0;
      r_resp[2]   <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      o_Tx_Data   <= '0;
      o_Tx_Start  <= 1'b0;
      o_Dth_Start <= '0;
    end else begin
      o_Tx_Start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_Rx_Done) begin
            r_count <= '0;
            if (i_Rx_Data == ADDRESS) begin
              r_state <= S_RX_CMD;
            end else begin
              r_skip  <= 2'd2;
              r_state <= S_SKIP;
            end
          end
        end
        S_SKIP: begin
          if (i_Rx_Done) begin
            r_count <= '0;
            r_skip  <= r_skip - 2'd1;
            if (r_skip == 2'd1) r_state <= S_IDLE;
          end else if (w_rx_expired) begin
            r_state <= S_IDLE;
          end else begin
            r_count <= r_count + c_CNT_ONE;
          end
        end
        S_RX_CMD: begin
          if (i_Rx_Done) begin
            r_cmd   <= i_Rx_Data;
            r_count <= '0;
            r_state <= S_RX_CHAN;
          end else if (w_rx_expired) begin
            r_state <= S_IDLE;
          end else begin
            r_count <= r_count + c_CNT_ONE;
          end
        end
        S_RX_CHAN: begin
          if (i_Rx_Done) begin
            r_chan  <= i_Rx_Data;
            r_count <= '0;
            r_state <= S_CHECK;
          end else if (w_rx_expired) begin
            r_state <= S_IDLE;
          end else begin
            r_count <= r_count + c_CNT_ONE;
          end
        end
        S_CHECK: begin
          r_idx <= '0;
          if (!w_cmd_ok) begin
            r_resp[0] <= 8'h2f;
            r_len     <= 2'd1;
            r_state   <= S_TX_SEND;
          end else if (!w_chan_ok) begin
            r_resp[0] <= 8'h3f;
            r_len     <= 2'd1;
            r_state   <= S_TX_SEND;
          end else begin
            o_Dth_Start <= w_onehot;
            r_count     <= '0;
            r_state     <= S_DTH_WAIT;
          end
        end
        S_DTH_WAIT: begin
          // Sensor flags take priority over a timeout landing on the same cycle.
          if (w_error || (w_done && (w_sum != w_slice[39:32]))) begin
            r_resp[0]   <= 8'h1f;
            r_len       <= 2'd1;
            o_Dth_Start <= '0;
            r_state     <= S_TX_SEND;
          end else if (w_done) begin
            case (r_cmd)
              8'h04: begin
                r_resp[0] <= 8'h02;
                r_resp[1] <= w_slice[7:0];
                r_resp[2] <= w_slice[15:8];
                r_len     <= 2'd3;
              end
              8'h05: begin
                r_resp[0] <= 8'h01;
                r_resp[1] <= w_slice[23:16];
                r_resp[2] <= w_slice[31:24];
                r_len     <= 2'd3;
              end
              default: begin
                r_resp[0] <= 8'h00;
                r_len     <= 2'd1;
              end
            endcase
            o_Dth_Start <= '0;
            r_state     <= S_TX_SEND;
          end else if (r_count == c_DTH_LAST) begin
            r_resp[0]   <= 8'h1e;
            r_len       <= 2'd1;
            o_Dth_Start <= '0;
            r_state     <= S_TX_SEND;
          end else begin
            r_count <= r_count + c_CNT_ONE;
          end
        end
        S_TX_SEND: begin
          o_Tx_Data  <= r_resp[r_idx];
          o_Tx_Start <= 1'b1;
          r_state    <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (i_Tx_Done) begin
            if ((r_idx + 2'd1) == r_len) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_TX_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpga_multi_sensor_core.sv
//------------------------------------------------------------------------------
// Module   : tb_fpga_multi_sensor_core
// Brief    : Randomised frame-level bench for fpga_multi_sensor_core against a
//            response model derived from the protocol rules.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fpga_multi_sensor_core;

  localparam logic [7:0] ADDRESS     = 8'h00;
  localparam int         N           = 4;
  localparam int         DTH_TIMEOUT = 100;
  localparam int         RX_TIMEOUT  = 50;

  logic            r_clk = 1'b0;
  logic            r_reset_n = 1'b0;
  logic [7:0]      r_rx_data = '0;
  logic            r_rx_done = 1'b0;
  logic [40*N-1:0] r_dth_data = '0;
  logic [N-1:0]    r_dth_done = '0;
  logic [N-1:0]    r_dth_error = '0;
  logic            r_tx_done = 1'b0;
  logic [7:0]      w_tx_data;
  logic            w_tx_start;
  logic [N-1:0]    w_dth_start;
  logic            w_busy;

  int n_checks = 0;
  int n_errors = 0;
  logic r_any_start;

  fpga_multi_sensor_core #(
    .ADDRESS(ADDRESS), .N_SENSORS(N), .DTH_TIMEOUT(DTH_TIMEOUT), .RX_TIMEOUT(RX_TIMEOUT)
  ) dut (
    .i_Clock(r_clk), .i_Reset_n(r_reset_n), .i_Rx_Data(r_rx_data), .i_Rx_Done(r_rx_done),
    .i_Dth_Data(r_dth_data), .i_Dth_Done(r_dth_done), .i_Dth_Error(r_dth_error),
    .i_Tx_Done(r_tx_done), .o_Tx_Data(w_tx_data), .o_Tx_Start(w_tx_start),
    .o_Dth_Start(w_dth_start), .o_Busy(w_busy)
  );

  always #5 r_clk = ~r_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input logic [7:0] ch);
    return N'(1) << ch;
  endfunction

  task automatic tick();
    @(negedge r_clk);
    r_any_start = r_any_start | (w_dth_start != '0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    r_rx_data = b;
    r_rx_done = 1'b1;
    tick();
    r_rx_done = 1'b0;
  endtask

  task automatic junk(input logic [7:0] ch);
    r_dth_done  = N'($urandom) & ~onehot(ch);
    r_dth_error = N'($urandom) & ~onehot(ch);
  endtask

  task automatic wait_tx(output int lat);
    lat = 0;
    while (!w_tx_start && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [39:0] make_slice(input logic [7:0] b0, b1, b2, b3, input logic good);
    logic [7:0] b4;
    b4 = 8'((int'(b0) + int'(b1) + int'(b2) + int'(b3)) % 256);
    if (!good) b4 = b4 ^ 8'($urandom_range(1, 255));
    return {b4, b3, b2, b1, b0};
  endfunction

  // mode: 0 done, 1 error, 2 done+error together, 3 no flags (timeout)
  task automatic run_frame(input logic [7:0] addr, cmd, chan, input int mode,
                           input logic [39:0] slice, input int gap);
    logic [7:0] exp_q[$];
    logic       exp_sensor;
    int         lat, hi, d, sum;
    exp_q = {};
    exp_sensor = 1'b0;
    sum = (int'(slice[7:0]) + int'(slice[15:8]) + int'(slice[23:16]) + int'(slice[31:24])) % 256;
    if (addr == ADDRESS) begin
      if (cmd != 8'h03 && cmd != 8'h04 && cmd != 8'h05) exp_q.push_back(8'h2f);
      else if (int'(chan) >= N) exp_q.push_back(8'h3f);
      else begin
        exp_sensor = 1'b1;
        if (mode == 3) exp_q.push_back(8'h1e);
        else if (mode != 0 || sum != int'(slice[39:32])) exp_q.push_back(8'h1f);
        else if (cmd == 8'h03) exp_q.push_back(8'h00);
        else if (cmd == 8'h04) exp_q = {8'h02, slice[7:0], slice[15:8]};
        else exp_q = {8'h01, slice[23:16], slice[31:24]};
      end
    end
    for (int k = 0; k < N; k++) r_dth_data[40*k +: 40] = {8'($urandom), 32'($urandom)};
    if (int'(chan) < N) r_dth_data[40*chan +: 40] = slice;
    r_any_start = 1'b0;

    send_byte(addr);
    repeat (gap) tick();
    send_byte(cmd);
    repeat (gap) tick();
    send_byte(chan);

    if (exp_sensor) begin
      lat = 0;
      while (w_dth_start == '0 && lat < 10) begin
        tick();
        lat++;
      end
      check_eq("dth_start", w_dth_start, onehot(chan));
      check_eq("dth_latency", lat, 1);
      if (mode == 3) begin
        hi = 0;
        while (w_dth_start != '0 && hi < DTH_TIMEOUT + 20) begin
          junk(chan);
          hi++;
          tick();
        end
        check_eq("dth_hold_cycles", hi, DTH_TIMEOUT);
      end else begin
        d = $urandom_range(0, 40);
        repeat (d) begin
          junk(chan);
          r_rx_done = ($urandom_range(0, 9) == 0);
          r_rx_data = 8'($urandom);
          tick();
        end
        r_rx_done = 1'b0;
        check_eq("dth_held", w_dth_start, onehot(chan));
        r_dth_done  = (mode != 1) ? onehot(chan) : '0;
        r_dth_error = (mode != 0) ? onehot(chan) : '0;
        tick();
        check_eq("dth_release", w_dth_start, '0);
      end
      r_dth_done  = '0;
      r_dth_error = '0;
    end

    if (exp_q.size() == 0) begin
      repeat (5) tick();
      check_eq("skip_no_tx", {w_tx_start, r_any_start}, 2'b00);
      check_eq("skip_idle", w_busy, 1'b0);
    end
    foreach (exp_q[i]) begin
      wait_tx(lat);
      check_eq("tx_start", w_tx_start, 1'b1);
      if (i == 0) check_eq("tx_latency", lat, exp_sensor ? 1 : 2);
      check_eq("tx_data", w_tx_data, exp_q[i]);
      tick();
      check_eq("tx_pulse", w_tx_start, 1'b0);
      repeat ($urandom_range(0, 5)) tick();
      r_tx_done = 1'b1;
      tick();
      r_tx_done = 1'b0;
    end
    if (exp_q.size() != 0) begin
      check_eq("done_idle", w_busy, 1'b0);
      check_eq("hold_data", w_tx_data, exp_q[exp_q.size()-1]);
      if (!exp_sensor) check_eq("no_dth_start", r_any_start, 1'b0);
    end
  endtask

  initial begin
    int lat;
    logic [7:0] a, c, ch;
    logic [39:0] s;
    r_any_start = 1'b0;
    repeat (3) tick();
    check_eq("rst_tx_data", w_tx_data, '0);
    check_eq("rst_tx_start", w_tx_start, 1'b0);
    check_eq("rst_dth_start", w_dth_start, '0);
    check_eq("rst_busy", w_busy, 1'b0);
    r_reset_n = 1'b1;
    tick();

    run_frame(8'h00, 8'h04, 8'h02, 0, {8'h5A, 8'h00, 8'h3C, 8'h05, 8'h19}, 0);
    run_frame(8'h00, 8'h05, 8'h01, 0, {8'h00, 8'h12, 8'h34, 8'h01, 8'h02}, 1);
    run_frame(8'h00, 8'h05, 8'h01, 2, make_slice(8'h10, 8'h01, 8'h20, 8'h02, 1'b1), 0);
    run_frame(8'h00, 8'h03, 8'h00, 3, make_slice(8'h10, 8'h01, 8'h20, 8'h02, 1'b1), 0);
    run_frame(8'h00, 8'h07, 8'h00, 0, '0, 0);
    run_frame(8'h00, 8'h04, 8'h09, 0, '0, 2);
    run_frame(8'h05, 8'h04, 8'h00, 0, '0, 3);

    // Partial frame abandoned after the inter-byte timeout.
    send_byte(8'h00);
    send_byte(8'h04);
    repeat (RX_TIMEOUT - 1) tick();
    check_eq("rx_timeout_hold", w_busy, 1'b1);
    tick();
    check_eq("rx_timeout_idle", w_busy, 1'b0);
    run_frame(8'h00, 8'h03, 8'h00, 0, make_slice(8'h17, 8'h00, 8'h30, 8'h00, 1'b1), 0);

    // Reset while waiting for the first transmit handshake.
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h02);
    r_dth_data[80 +: 40] = make_slice(8'h19, 8'h05, 8'h3C, 8'h00, 1'b1);
    repeat (3) tick();
    r_dth_done = 4'b0100;
    tick();
    r_dth_done = '0;
    wait_tx(lat);
    check_eq("rst_mid_first", w_tx_data, 8'h02);
    tick();
    r_reset_n = 1'b0;
    tick();
    check_eq("rst_mid_tx_data", w_tx_data, '0);
    check_eq("rst_mid_tx_start", w_tx_start, 1'b0);
    check_eq("rst_mid_dth", w_dth_start, '0);
    check_eq("rst_mid_busy", w_busy, 1'b0);
    r_reset_n = 1'b1;
    tick();
    run_frame(8'h00, 8'h04, 8'h02, 0, make_slice(8'h19, 8'h05, 8'h3C, 8'h00, 1'b1), 0);

    for (int n = 0; n < 40; n++) begin
      a  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : ADDRESS;
      c  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(3, 5));
      ch = 8'($urandom_range(0, 5));
      s  = make_slice(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      $urandom_range(0, 3) != 0);
      run_frame(a, c, ch, $urandom_range(0, 3), s, $urandom_range(0, 10));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
